// File: rtl/mlp_result_buffer_if.sv
// Result-buffer stream interface.
// Groups the capture-side beat (in_valid_i/in_data_i) and the drain-side
// valid/ready stream (out_valid_o/out_ready_i/out_data_o/out_last_o).
// master: the surrounding system (FSM feeding beats, host draining).
// slave : the result buffer itself.
interface mlp_result_buffer_if #(
    parameter int unsigned DataWidth = 8
);
    logic                 in_valid_i;
    logic [DataWidth-1:0] in_data_i;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic [DataWidth-1:0] out_data_o;
    logic                 out_last_o;

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o
    );

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output out_valid_o,
        output out_data_o,
        output out_last_o
    );
endinterface

// File: rtl/mlp_result_buffer.sv
// MLP result buffer: captures one Depth-beat result frame (no backpressure),
// then drains it to the host over valid/ready with a last flag, optionally
// clamping negative words to zero on the way out.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   bus          slave side of mlp_result_buffer_if (capture beat + drain stream)
//   buf_idle_o   high while idle; host may start the next inference
//   overflow_o   sticky: a beat arrived while draining (dropped)
//   frame_cnt_o  count of fully drained frames, wraps
module mlp_result_buffer #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 256,
    parameter bit          Relu      = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mlp_result_buffer_if.slave   bus,
    output logic                 buf_idle_o,
    output logic                 overflow_o,
    output logic [15:0]          frame_cnt_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCapture = 2'd1,
        StDrain   = 2'd2
    } state_e;

    state_e               state_q;
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [DataWidth-1:0] mem [Depth];
    logic                 wr_en;
    logic [DataWidth-1:0] rd_word;
    logic [DataWidth-1:0] rd_word_f;

    // Beats are accepted in Idle and Capture; wr_ptr is always 0 in Idle.
    assign wr_en = bus.in_valid_i && !rst_i && (state_q != StDrain);

    // Frame storage; contents are not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= bus.in_data_i;
        end
    end

    // Output path: optional ReLU on the word under the read pointer.
    always_comb begin
        rd_word   = mem[rd_ptr_q];
        rd_word_f = rd_word;
        if (Relu && rd_word[DataWidth-1]) begin
            rd_word_f = '0;
        end
    end

    assign bus.out_valid_o = out_valid_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.out_data_o  = out_valid_q ? rd_word_f : '0;

    // Control FSM with registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            buf_idle_o  <= 1'b1;
            overflow_o  <= 1'b0;
            frame_cnt_o <= 16'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid_i) begin
                        wr_ptr_q   <= wr_ptr_q + PtrW'(1);
                        buf_idle_o <= 1'b0;
                        state_q    <= StCapture;
                    end
                end
                StCapture: begin
                    if (bus.in_valid_i) begin
                        // Pointer wraps naturally to 0 on the final beat.
                        wr_ptr_q <= wr_ptr_q + PtrW'(1);
                        if (wr_ptr_q == LastPtr) begin
                            out_valid_q <= 1'b1;
                            out_last_q  <= (rd_ptr_q == LastPtr);
                            state_q     <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (bus.in_valid_i) begin
                        overflow_o <= 1'b1;
                    end
                    if (bus.out_ready_i) begin
                        rd_ptr_q   <= rd_ptr_q + PtrW'(1);
                        out_last_q <= ((rd_ptr_q + PtrW'(1)) == LastPtr);
                        if (rd_ptr_q == LastPtr) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            buf_idle_o  <= 1'b1;
                            frame_cnt_o <= frame_cnt_o + 16'd1;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_result_buffer.sv
// Scoreboard bench for mlp_result_buffer: two instances (ReLU on / off) share
// the same stimulus; expected drain words are queued as beats are issued and a
// negedge monitor pops and compares on every accepted drain beat.
module tb_mlp_result_buffer;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    always #5 clk = ~clk;

    mlp_result_buffer_if #(.DataWidth(DW)) bus_r ();
    mlp_result_buffer_if #(.DataWidth(DW)) bus_p ();

    assign bus_r.in_valid_i  = in_valid;
    assign bus_r.in_data_i   = in_data;
    assign bus_r.out_ready_i = out_ready;
    assign bus_p.in_valid_i  = in_valid;
    assign bus_p.in_data_i   = in_data;
    assign bus_p.out_ready_i = out_ready;

    logic        idle_r, ovf_r, idle_p, ovf_p;
    logic [15:0] fc_r, fc_p;

    mlp_result_buffer #(.DataWidth(DW), .Depth(DEPTH), .Relu(1'b1)) u_relu (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus_r),
        .buf_idle_o  (idle_r),
        .overflow_o  (ovf_r),
        .frame_cnt_o (fc_r)
    );

    mlp_result_buffer #(.DataWidth(DW), .Depth(DEPTH), .Relu(1'b0)) u_pass (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus_p),
        .buf_idle_o  (idle_p),
        .overflow_o  (ovf_p),
        .frame_cnt_o (fc_p)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] exp_p[$];
    logic [DW-1:0] frame [DEPTH];
    int            exp_frames = 0;
    logic          exp_ovf    = 1'b0;
    int            ready_mode = 0;

    task automatic check(input string name, input int dut, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, dut, act, exp, $time);
        end
    endtask

    // Reference ReLU: negative two's-complement values become zero.
    function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] w);
        return ($signed(w) < 0) ? DW'(0) : w;
    endfunction

    // Host ready: always-on or 50% random, updated just after each edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor / scoreboard.
    logic          prev_stall [2];
    logic [DW-1:0] prev_data  [2];
    logic          prev_last  [2];
    int            beat_idx   [2];
    int            xfers      [2];
    logic          idle_chk   [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            prev_stall[d] = 1'b0;
            prev_data[d]  = '0;
            prev_last[d]  = 1'b0;
            beat_idx[d]   = 0;
            xfers[d]      = 0;
            idle_chk[d]   = 1'b0;
        end
    end

    always @(negedge clk) begin
        logic          v, l, idl;
        logic [DW-1:0] data, e;
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                prev_stall[d] = 1'b0;
                beat_idx[d]   = 0;
                idle_chk[d]   = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                v    = (d == 0) ? bus_r.out_valid_o : bus_p.out_valid_o;
                l    = (d == 0) ? bus_r.out_last_o  : bus_p.out_last_o;
                data = (d == 0) ? bus_r.out_data_o  : bus_p.out_data_o;
                idl  = (d == 0) ? idle_r : idle_p;
                if (idle_chk[d]) begin
                    check("idle_after_last", d, idl, 1);
                    check("valid_after_last", d, v, 0);
                    idle_chk[d] = 1'b0;
                end
                if (prev_stall[d]) begin
                    check("stall_valid", d, v, 1);
                    check("stall_data", d, data, prev_data[d]);
                    check("stall_last", d, l, prev_last[d]);
                end
                if (!v) begin
                    check("data_zero_when_invalid", d, data, 0);
                    check("last_low_when_invalid", d, l, 0);
                end
                if (v && out_ready) begin
                    total++;
                    if (((d == 0) ? exp_r.size() : exp_p.size()) == 0) begin
                        bad++;
                        $display("FAIL unexpected_beat dut%0d: got data %0h with nothing expected", d, data);
                    end else begin
                        e = (d == 0) ? exp_r.pop_front() : exp_p.pop_front();
                        if (data != e) begin
                            bad++;
                            $display("FAIL drain_data dut%0d beat %0d: got %0h want %0h", d, beat_idx[d], data, e);
                        end
                    end
                    check("drain_last", d, l, (beat_idx[d] == DEPTH - 1) ? 1 : 0);
                    if (beat_idx[d] == DEPTH - 1) begin
                        beat_idx[d] = 0;
                        idle_chk[d] = 1'b1;
                    end else begin
                        beat_idx[d]++;
                    end
                    xfers[d]++;
                end
                prev_stall[d] = v && !out_ready;
                prev_data[d]  = data;
                prev_last[d]  = l;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string name);
        check({name, "_valid"}, 0, bus_r.out_valid_o, 0);
        check({name, "_valid"}, 1, bus_p.out_valid_o, 0);
        check({name, "_last"}, 0, bus_r.out_last_o, 0);
        check({name, "_data"}, 0, bus_r.out_data_o, 0);
        check({name, "_idle"}, 0, idle_r, 1);
        check({name, "_idle"}, 1, idle_p, 1);
        check({name, "_ovf"}, 0, ovf_r, exp_ovf);
        check({name, "_ovf"}, 1, ovf_p, exp_ovf);
        check({name, "_fcnt"}, 0, fc_r, exp_frames);
        check({name, "_fcnt"}, 1, fc_p, exp_frames);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        exp_r.delete();
        exp_p.delete();
        exp_frames = 0;
        exp_ovf    = 1'b0;
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) frame[k] = DW'($urandom);
    endtask

    // Issue the frame held in 'frame', queuing the expected drain words.
    task automatic send_frame(input bit gaps);
        check("idle_before_frame", 0, idle_r, 1);
        check("idle_before_frame", 1, idle_p, 1);
        for (int k = 0; k < DEPTH; k++) begin
            if (gaps && (k % 3 == 2)) begin
                in_valid = 1'b0;
                tick();
            end
            in_valid = 1'b1;
            in_data  = frame[k];
            exp_r.push_back(relu_ref(frame[k]));
            exp_p.push_back(frame[k]);
            if (k == DEPTH - 1) begin
                check("valid_before_last_beat", 0, bus_r.out_valid_o, 0);
                check("valid_before_last_beat", 1, bus_p.out_valid_o, 0);
            end
            tick();
        end
        in_valid = 1'b0;
        check("valid_one_cycle_after_last_beat", 0, bus_r.out_valid_o, 1);
        check("valid_one_cycle_after_last_beat", 1, bus_p.out_valid_o, 1);
    endtask

    task automatic finish_frame(input int x0_r, input int x0_p, input bit check_min);
        int cyc;
        cyc = 0;
        while (!(idle_r && idle_p) && cyc < 8 * DEPTH) begin
            tick();
            cyc++;
        end
        check("drain_completes", 0, idle_r && idle_p, 1);
        if (check_min) check("drain_cycles", 0, cyc, DEPTH);
        exp_frames++;
        check("transfers", 0, xfers[0] - x0_r, DEPTH);
        check("transfers", 1, xfers[1] - x0_p, DEPTH);
        check("exp_left", 0, exp_r.size(), 0);
        check("exp_left", 1, exp_p.size(), 0);
        check("frame_cnt", 0, fc_r, exp_frames);
        check("frame_cnt", 1, fc_p, exp_frames);
        check("overflow", 0, ovf_r, exp_ovf);
        check("overflow", 1, ovf_p, exp_ovf);
    endtask

    task automatic run_frame(input bit gaps, input bit check_min);
        int x0_r, x0_p;
        x0_r = xfers[0];
        x0_p = xfers[1];
        send_frame(gaps);
        finish_frame(x0_r, x0_p, check_min);
    endtask

    initial begin
        int x0_r, x0_p;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        do_reset();
        check_state("reset");

        // Ramp frame, continuous beats and ready: both ReLU settings.
        for (int k = 0; k < DEPTH; k++) frame[k] = DW'(k);
        ready_mode = 0;
        run_frame(1'b0, 1'b1);

        // Gapped capture, random host ready.
        fill_random();
        ready_mode = 1;
        run_frame(1'b1, 1'b0);

        // Stray beat during drain: dropped, overflow sticks.
        fill_random();
        x0_r = xfers[0];
        x0_p = xfers[1];
        send_frame(1'b0);
        repeat (10) tick();
        check("still_draining", 0, idle_r, 0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_valid = 1'b0;
        exp_ovf  = 1'b1;
        check("overflow_set", 0, ovf_r, 1);
        check("overflow_set", 1, ovf_p, 1);
        finish_frame(x0_r, x0_p, 1'b0);
        repeat (3) tick();
        check("overflow_sticky", 0, ovf_r, 1);

        // Reset mid-capture, then a clean frame.
        fill_random();
        for (int k = 0; k < 100; k++) begin
            in_valid = 1'b1;
            in_data  = frame[k];
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        check("partial_no_valid", 0, bus_r.out_valid_o, 0);
        check("partial_not_idle", 0, idle_r, 0);
        do_reset();
        check_state("reset_mid_capture");
        fill_random();
        ready_mode = 1;
        run_frame(1'b0, 1'b0);

        // Three back-to-back frames from reset.
        do_reset();
        check_state("reset_b2b");
        ready_mode = 0;
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(1'b0, 1'b1);
        end
        check("frame_cnt_three", 0, fc_r, 3);
        check("frame_cnt_three", 1, fc_p, 3);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
